piso_serial_tx: RTL
===================

# piso_serial_tx

Parallel-in serial-out transmitter built from D flip-flop stages. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with framing strobes. A one-word holding register allows back-to-back frames with no idle gap. It is the sending end of the serial bit stream that the team's flip-flop shift-register receivers capture.

## Interface
- WIDTH, 8: bits per frame; must be at least 2.
- MSB_FIRST, 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- load_data  in  WIDTH  parallel word to transmit.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  block can accept a word; equals !hold_full (combinational from state only).
- ser_out  out  1  serial data bit; 0 when ser_valid=0.
- ser_out_n  out  1  always the complement of ser_out.
- ser_valid  out  1  ser_out carries a frame bit this cycle.
- frame_start  out  1  first bit of a frame.
- ser_last  out  1  last bit of a frame.
- busy  out  1  ser_valid | hold_full.

## Operation
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter presents one bit per cycle; bit counter runs 0..WIDTH-1, width $clog2(WIDTH).
- IDLE + accept: word goes directly into the shifter, counter=0, next state SHIFT. The holding register stays empty.
- SHIFT + accept, not on the last-bit cycle: word goes into the holding register; hold_full=1.
- Last-bit cycle (counter=WIDTH-1), chosen in this priority:
  - if hold_full: shifter<=hold, counter<=0, hold_full<=0, stay in SHIFT.
  - else if accept occurs this cycle: shifter<=load_data, counter<=0, stay in SHIFT.
  - else: go to IDLE.
- Simultaneous last bit, hold_full=1 and load_valid: no accept, because load_ready=0. The word is accepted on a later cycle.
- Outputs registered: ser_out, frame_start and ser_last are all driven from flops.
  - ser_out follows MSB_FIRST ordering.
  - frame_start=1 when counter=0 in SHIFT.
  - ser_last=1 when counter=WIDTH-1.
- The shifter captures a word only at the moment it is accepted. Later changes to load_data have no effect on the frame in flight.
- Reset, asserted at any time including mid-frame: state IDLE, counter 0, hold_full 0, shifter 0. The in-flight frame and the held word are discarded.
- Reset values of outputs: ser_out=0, ser_out_n=1, ser_valid=0, frame_start=0, ser_last=0, busy=0, load_ready=1.

## Timing
- Latency: a word accepted at edge N from IDLE presents its first bit in the cycle after edge N, with ser_valid=1 and frame_start=1.
- Frame length: exactly WIDTH consecutive ser_valid cycles.
- Back-to-back frames: a held word starts in the cycle immediately after ser_last. There is zero gap and ser_valid stays 1.
- Throughput: one word per WIDTH cycles sustained. At most two words in flight: one in the shifter, one held.
- load_ready drops in the cycle after a word enters the holding register. It rises in the cycle after the held word moves into the shifter.
- Reset takes effect asynchronously. After rst deasserts, the first edge can accept a word.

## Structure
- Shared package/header piso_pkg holds:
  - the state encoding localparams (ST_IDLE=0, ST_SHIFT=1);
  - the constant function for counter width.
- Sub-module piso_shift_reg (parameter WIDTH, MSB_FIRST) holds:
  - the WIDTH-bit shift register;
  - parallel load and shift-enable inputs;
  - serial output bit.
- The top level holds the FSM, counter, holding register and strobes.

## Test plan
- Reset values: assert rst mid-simulation with no load. Required: ser_out=0, ser_out_n=1, ser_valid=0, load_ready=1, busy=0.
- Single frame: WIDTH=8, MSB_FIRST=1, load 0xA5 from IDLE at edge 0. Required:
  - ser_out = 1,0,1,0,0,1,0,1 in cycles 1..8;
  - frame_start in cycle 1 only, ser_last in cycle 8 only;
  - ser_valid=0 in cycle 9.
- LSB first: MSB_FIRST=0, load 0x01. Required: ser_out=1 in cycle 1, then 0 for cycles 2..8; ser_out_n is the complement throughout.
- Back-to-back: load 0xF0, then load 0x0F in cycle 3 (held). Required:
  - load_ready=0 from cycle 4 until cycle 9;
  - bits of 0x0F in cycles 9..16 with no ser_valid gap;
  - frame_start in cycle 9.
- Backpressure: with hold_full=1, keep load_valid=1 with 0x3C. Required: no accept until load_ready=1, and 0x3C is transmitted exactly once.
- Reset mid-frame: assert rst in cycle 4 of frame 0xA5 while a word is held. Required:
  - outputs return to reset values immediately;
  - no remaining bits of either word appear after release.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the piso_serial_tx transmitter.
//   state_t   : FSM state encoding (ST_IDLE = 0, ST_SHIFT = 1)
//   cnt_width : bit-counter width for a given frame width
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: WIDTH-bit parallel-load shift register with a one-bit serial tap.
//   clk, rst  : clock, asynchronous active-high reset (clears the register)
//   load      : capture load_data (takes priority over shift)
//   load_data : parallel word
//   shift     : advance one bit toward the serial tap, zero-filling behind
//   ser_bit   : current head bit (MSB when MSB_FIRST=1, else LSB)
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             ser_bit
);

  logic [WIDTH-1:0] q;

  // Zero-fill means the register drains to all-zero after a full frame,
  // so the serial tap idles at 0 without a separate gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign ser_bit = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in serial-out transmitter with a one-word holding
// register for gapless back-to-back frames.
//   clk, rst    : clock, asynchronous active-high reset
//   load_data   : WIDTH-bit word to send
//   load_valid  : load_data valid; accepted when load_ready is also high
//   load_ready  : !hold_full
//   ser_out     : serial bit (0 when idle), ser_out_n its complement
//   ser_valid   : ser_out carries a frame bit
//   frame_start : first bit of a frame, ser_last : last bit of a frame
//   busy        : ser_valid | hold_full
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_out_n,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             hold_full, hold_full_nx;
  logic [WIDTH-1:0] hold;
  logic             hold_wr;
  logic             accept;
  logic             sr_load, sr_shift;
  logic [WIDTH-1:0] sr_data;

  assign accept = load_valid && !hold_full;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hold_full_nx = hold_full;
    hold_wr      = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_data      = load_data;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sr_load  = 1'b1;
          state_nx = ST_SHIFT;
          cnt_nx   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt != LAST) begin
          sr_shift = 1'b1;
          cnt_nx   = cnt + 1'b1;
          if (accept) begin
            hold_wr      = 1'b1;
            hold_full_nx = 1'b1;
          end
        end else if (hold_full) begin
          // A held word wins over a new offer; load_ready is low so none is taken.
          sr_load      = 1'b1;
          sr_data      = hold;
          cnt_nx       = '0;
          hold_full_nx = 1'b0;
        end else if (accept) begin
          sr_load = 1'b1;
          cnt_nx  = '0;
        end else begin
          // Final shift drains the last data bit, leaving the shifter all-zero.
          sr_shift = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hold_full   <= 1'b0;
      hold        <= '0;
      frame_start <= 1'b0;
      ser_last    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      hold_full   <= hold_full_nx;
      if (hold_wr) hold <= load_data;
      frame_start <= (state_nx == ST_SHIFT) && (cnt_nx == '0);
      ser_last    <= (state_nx == ST_SHIFT) && (cnt_nx == LAST);
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_data (sr_data),
    .shift     (sr_shift),
    .ser_bit   (ser_out)
  );

  assign ser_out_n  = ~ser_out;
  assign ser_valid  = (state == ST_SHIFT);
  assign load_ready = ~hold_full;
  assign busy       = ser_valid | hold_full;

endmodule
